// File: rtl/nri_div_sequencer.sv
// Non-restoring integer divider for the M-extension execute stage: a fix-up unit
// and the multi-cycle sequencer that owns the datapath registers and shortcuts.

module nri_div_corrections_unit #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_n,
  input  logic [N-1:0] i_d,
  input  logic [N-1:0] i_q,
  input  logic [N:0]   i_r,
  input  logic         i_signed,
  output logic [N-1:0] o_quot,
  output logic [N-1:0] o_rem
);
  logic [N:0]   d_ext, r_add, r_sub;
  logic [N-1:0] q_base;
  logic         n_neg, d_neg, r_neg, r_nz, fix_add, fix_sub;
  logic         unused_bits;

  assign unused_bits = ^{i_n[N-2:0], i_q[N-1]};

  always_comb begin
    d_ext  = {i_signed & i_d[N-1], i_d};
    r_add  = i_r + d_ext;
    r_sub  = i_r - d_ext;
    // Digits are +1/-1 stored as 1/0, so Q = 2P - (2^N - 1) == {P << 1 | 1} mod 2^N
    q_base = {i_q[N-2:0], 1'b1};
    n_neg  = i_signed & i_n[N-1];
    d_neg  = i_signed & i_d[N-1];
    r_neg  = i_r[N];
    r_nz   = |i_r;
    // Remainder must take the dividend's sign and may not equal +/-|d|
    fix_add = (r_nz && (r_neg != n_neg) && (r_neg != d_neg)) || (r_add == '0);
    fix_sub = (r_nz && (r_neg != n_neg) && (r_neg == d_neg)) || (r_sub == '0);
    o_quot = q_base;
    o_rem  = i_r[N-1:0];
    if (fix_add) begin
      o_quot = q_base - {{(N-1){1'b0}}, 1'b1};
      o_rem  = r_add[N-1:0];
    end else if (fix_sub) begin
      o_quot = q_base + {{(N-1){1'b0}}, 1'b1};
      o_rem  = r_sub[N-1:0];
    end
  end
endmodule

// state | meaning
// IDLE  | ready for a request
// ITER  | one non-restoring step per cycle, dividend bits shifted in MSB first
// CORR  | fix-up of quotient/remainder, result registered
// DONE  | result valid, held until consumer accepts
module nri_div_sequencer #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_data_n,
  input  logic [N-1:0] i_data_d,
  input  logic         i_signed,
  input  logic         i_rem,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_data,
  output logic         o_busy
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d, n_q, n_d, d_q, d_d, data_q, data_d;
  logic          sgn_q, sgn_d, sel_rem_q, sel_rem_d;
  logic [N:0]    d_ext, r_shift;
  logic [N-1:0]  corr_quot, corr_rem;
  logic          accept, div_zero, ovf, sub;

  nri_div_corrections_unit #(.N(N)) u_corr (
    .i_n      (n_q),
    .i_d      (d_q),
    .i_q      (quo_q),
    .i_r      (rem_q),
    .i_signed (sgn_q),
    .o_quot   (corr_quot),
    .o_rem    (corr_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    n_d       = n_q;
    d_d       = d_q;
    sgn_d     = sgn_q;
    sel_rem_d = sel_rem_q;
    data_d    = data_q;
    accept    = (state_q == IDLE) && i_valid && !i_flush;
    div_zero  = (i_data_d == '0);
    ovf       = i_signed && (i_data_n == {1'b1, {(N-1){1'b0}}}) && (&i_data_d);
    d_ext     = {sgn_q & d_q[N-1], d_q};
    // N is a power of two, so N-1-cnt is the bitwise complement of the low bits
    r_shift   = {rem_q[N-1:0], n_q[~cnt_q[CW-2:0]]};
    sub       = 1'b0;

    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            n_d       = i_data_n;
            d_d       = i_data_d;
            sgn_d     = i_signed;
            sel_rem_d = i_rem;
            quo_d     = '0;
            rem_d     = {(N+1){i_signed & i_data_n[N-1]}};
            cnt_d     = '0;
            if (div_zero) begin
              state_d = DONE;
              data_d  = i_rem ? i_data_n : '1;
            end else if (ovf) begin
              state_d = DONE;
              data_d  = i_rem ? '0 : i_data_n;
            end else begin
              state_d = ITER;
            end
          end
        end
        ITER: begin
          sub   = (rem_q[N] == d_ext[N]);
          rem_d = sub ? (r_shift - d_ext) : (r_shift + d_ext);
          quo_d = {quo_q[N-2:0], sub};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = CORR;
        end
        CORR: begin
          data_d  = sel_rem_q ? corr_rem : corr_quot;
          state_d = DONE;
        end
        DONE: begin
          if (i_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      n_q       <= '0;
      d_q       <= '0;
      sgn_q     <= 1'b0;
      sel_rem_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      n_q       <= n_d;
      d_q       <= d_d;
      sgn_q     <= sgn_d;
      sel_rem_q <= sel_rem_d;
      data_q    <= data_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_data  = data_q;
endmodule

// File: tb/tb_nri_div_sequencer.sv
// Directed bench for nri_div_sequencer (N=32): results, latency, shortcuts,
// backpressure, flush and mid-operation reset.

module tb_nri_div_sequencer;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data_n = '0;
  logic [31:0] i_data_d = '0;
  logic        i_signed = 1'b0;
  logic        i_rem = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_busy;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] d;
    logic        s;
    logic        r;
    logic [31:0] exp;
  } vec_t;

  nri_div_sequencer #(.N(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data_n (i_data_n),
    .i_data_d (i_data_d),
    .i_signed (i_signed),
    .i_rem    (i_rem),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Issues one request and returns the first valid result and its latency (-1 on timeout).
  task automatic run_op(input logic [31:0] n, input logic [31:0] d, input logic s,
                        input logic r, input logic drain,
                        output logic [31:0] data, output int lat);
    int b = 0;
    while (!o_ready && b < 200) begin
      @(posedge i_clk); #1; b++;
    end
    i_data_n = n; i_data_d = d; i_signed = s; i_rem = r; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1; lat++;
    end
    if (!o_valid) lat = -1;
    data = o_data;
    if (drain) begin
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", o_data); end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_unsigned();
    vec_t v[6];
    logic [31:0] data;
    int lat;
    v[0] = '{32'd100, 32'd7, 1'b0, 1'b0, 32'd14};
    v[1] = '{32'd100, 32'd7, 1'b0, 1'b1, 32'd2};
    v[2] = '{32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF};
    v[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd1};
    v[4] = '{32'd5, 32'd10, 1'b0, 1'b1, 32'd5};
    v[5] = '{32'hFFFFFFFF, 32'd16, 1'b0, 1'b1, 32'd15};
    foreach (v[i]) begin
      run_op(v[i].n, v[i].d, v[i].s, v[i].r, 1'b1, data, lat);
      n_checks++;
      if (data !== v[i].exp) begin
        n_fail++; $display("FAIL unsigned_data[%0d]: got %h expected %h", i, data, v[i].exp);
      end
      n_checks++;
      if (lat != 34) begin
        n_fail++; $display("FAIL unsigned_latency[%0d]: got %0d expected 34", i, lat);
      end
    end
  endtask

  task automatic test_signed();
    vec_t v[8];
    logic [31:0] data;
    int lat;
    v[0] = '{32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD};
    v[1] = '{32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF};
    v[2] = '{32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD};
    v[3] = '{32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001};
    v[4] = '{32'hFFFFFFF8, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd4};
    v[5] = '{32'hFFFFFFF8, 32'hFFFFFFFE, 1'b1, 1'b1, 32'd0};
    v[6] = '{32'hFFFFFFF7, 32'd4, 1'b1, 1'b0, 32'hFFFFFFFE};
    v[7] = '{32'h80000000, 32'd2, 1'b1, 1'b0, 32'hC0000000};
    foreach (v[i]) begin
      run_op(v[i].n, v[i].d, v[i].s, v[i].r, 1'b1, data, lat);
      n_checks++;
      if (data !== v[i].exp) begin
        n_fail++; $display("FAIL signed_data[%0d]: got %h expected %h", i, data, v[i].exp);
      end
      n_checks++;
      if (lat != 34) begin
        n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected 34", i, lat);
      end
    end
  endtask

  task automatic test_div_zero();
    vec_t v[4];
    logic [31:0] data;
    int lat;
    v[0] = '{32'h12345678, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF};
    v[1] = '{32'h12345678, 32'd0, 1'b1, 1'b1, 32'h12345678};
    v[2] = '{32'h12345678, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF};
    v[3] = '{32'h12345678, 32'd0, 1'b0, 1'b1, 32'h12345678};
    foreach (v[i]) begin
      run_op(v[i].n, v[i].d, v[i].s, v[i].r, 1'b1, data, lat);
      n_checks++;
      if (data !== v[i].exp) begin
        n_fail++; $display("FAIL div_zero_data[%0d]: got %h expected %h", i, data, v[i].exp);
      end
      n_checks++;
      if (lat != 1) begin
        n_fail++; $display("FAIL div_zero_latency[%0d]: got %0d expected 1", i, lat);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[4];
    int   exp_lat[4];
    logic [31:0] data;
    int lat;
    v[0] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000}; exp_lat[0] = 1;
    v[1] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000}; exp_lat[1] = 1;
    v[2] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000}; exp_lat[2] = 34;
    v[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000}; exp_lat[3] = 34;
    foreach (v[i]) begin
      run_op(v[i].n, v[i].d, v[i].s, v[i].r, 1'b1, data, lat);
      n_checks++;
      if (data !== v[i].exp) begin
        n_fail++; $display("FAIL overflow_data[%0d]: got %h expected %h", i, data, v[i].exp);
      end
      n_checks++;
      if (lat != exp_lat[i]) begin
        n_fail++; $display("FAIL overflow_latency[%0d]: got %0d expected %0d", i, lat, exp_lat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] data;
    int lat;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, data, lat);
    n_checks++;
    if (data !== 32'd14) begin n_fail++; $display("FAIL bp_data: got %h expected %h", data, 32'd14); end
    for (int k = 0; k < 10; k++) begin
      i_data_n = $urandom; i_data_d = 32'd3; i_valid = 1'b1; i_rem = 1'b1;
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, o_valid); end
      n_checks++; if (o_data !== 32'd14) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", k, o_data, 32'd14); end
      n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", k, o_ready); end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", o_ready); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_flush();
    logic [31:0] data;
    int lat;
    int seen;
    i_data_n = 32'd50; i_data_d = 32'd5; i_signed = 1'b0; i_rem = 1'b0;
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept: busy got %b expected 0", o_busy); end

    i_data_n = 32'd1000; i_data_d = 32'd3; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b expected 1", o_busy); end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", o_ready); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen++;
      @(posedge i_clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen); end
    run_op(32'd1000, 32'd3, 1'b0, 1'b0, 1'b1, data, lat);
    n_checks++; if (data !== 32'd333) begin n_fail++; $display("FAIL flush_next_data: got %h expected %h", data, 32'd333); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL flush_next_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] data;
    int lat;
    int seen;
    i_data_n = 32'h00001000; i_data_d = 32'd3; i_signed = 1'b1; i_rem = 1'b0; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", o_ready); end
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", o_data); end
    #3;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release_ready: got %b expected 1", o_ready); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen++;
      @(posedge i_clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d valid cycles expected 0", seen); end
    run_op(32'hFFFFFFFF, 32'd16, 1'b0, 1'b0, 1'b1, data, lat);
    n_checks++; if (data !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected %h", data, 32'h0FFFFFFF); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d expected 34", lat); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nri_div_sequencer.md
Name: nri_div_sequencer

Overview:
Multi-cycle controller for the non-restoring integer divider used by the M-extension execute stage (DIV/DIVU/REM/REMU).
- Accepts one operand pair per request over a valid/ready handshake.
- Runs N shift/add-subtract iterations on an (N+1)-bit partial remainder.
- Drives the existing nri_div_corrections_unit for the final quotient/remainder fix-up.
- Returns the selected result over a second valid/ready handshake.
- Owns the divider datapath registers, the iteration counter and the special-case shortcuts.

Parameters:
- N, 32, operand/result width in bits (N >= 4, power of two).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  sequencer can accept a request.
- i_data_n  in  N  dividend.
- i_data_d  in  N  divisor.
- i_signed  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- i_rem  in  1  1 = return remainder, 0 = return quotient.
- i_flush  in  1  synchronous abort of any in-flight or pending operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_data  out  N  quotient or remainder per the latched i_rem.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (i_rst_n low, asynchronous):
- State goes to IDLE.
- o_valid=0, o_data=0, o_busy=0, o_ready=1.
- Counter, partial remainder and quotient registers are cleared.

FSM states: IDLE, ITER, CORR, DONE.

IDLE:
- o_ready=1. Accept when i_valid && o_ready && !i_flush.
- On accept, latch n, d, i_signed and i_rem, clear the quotient, and load the partial remainder with the sign-extended (signed) or zero-extended (unsigned) dividend alignment.
- Next state:
  - DONE if d==0.
  - DONE if signed && n==2^(N-1) && d==all-ones.
  - Otherwise ITER with counter=0.

ITER, one quotient digit per cycle:
- If the partial remainder sign matches the divisor sign (signed), or the remainder is non-negative (unsigned): R = 2R - d.
- Otherwise: R = 2R + d.
- Shift the digit into the quotient register.
- The counter ($clog2(N)+1 bits) increments. After the N-th iteration (counter==N-1) go to CORR.

CORR (1 cycle):
- Feed latched n, d, quotient register, (N+1)-bit remainder and signed flag to nri_div_corrections_unit.
- Register its quotient or remainder output (per latched i_rem) into o_data.
- Go to DONE.

Shortcut results (registered into o_data on the accepting edge):
- Divide by zero: quotient = all-ones, remainder = n.
- Signed overflow: quotient = n, remainder = 0.

DONE:
- o_valid=1. o_data is held stable until i_ready.
- On i_valid... no: on o_valid && i_ready, go to IDLE and drop o_valid next cycle.
- o_ready=0 in DONE; no same-cycle re-accept.

Latency, measured from the accepting edge to the first cycle with o_valid=1:
- Normal operation: N+2 cycles.
- Shortcut: 1 cycle.
- Throughput: one operation per N+3 cycles minimum.

i_flush:
- Has priority over every other event in every state.
- Next state is IDLE, o_valid=0, and the result is discarded.
- A request presented in the same cycle as i_flush is not accepted.

Handshake rules:
- Operands are not sampled outside IDLE, and changes on them outside IDLE have no effect.
- i_ready without o_valid is ignored.

Reset mid-operation: immediate return to the reset values; no result is produced.

Results must match RISC-V M-extension semantics for all operand values.

Test Plan:
1. Unsigned 100 / 7, i_rem=0 then i_rem=1 -> o_data=14, then 2; o_valid exactly 34 cycles after accept (N=32).
2. Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
3. Divide by zero, n=0x12345678, d=0, signed and unsigned -> quotient 0xFFFFFFFF, remainder 0x12345678; o_valid 1 cycle after accept.
4. Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Same operands unsigned -> quotient 0, remainder 0x80000000 after the full 34 cycles.
5. Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid stays 1, o_data stable, o_ready=0. On i_ready=1, o_valid falls next cycle and o_ready rises.
6. Abort and reset: assert i_flush at iteration 5 -> IDLE next cycle, no o_valid, and the next request completes correctly. Pull i_rst_n low at iteration 20 -> outputs at reset values immediately, o_ready=1 after release.
